mic1_uart_loader: RTL and testbench



---
 rtl/mic1_loader_pkg.sv | 31 +++
 rtl/mic1_uart_rx.sv | 91 +++++++++
 rtl/mic1_uart_loader.sv | 186 ++++++++++++++++++
 tb/tb_mic1_uart_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mic1_loader_pkg.sv
// Shared types and helpers for the MIC-1 UART boot loader.
// MIC1_LOADER_CHECKSUM_EN adds the trailing checksum state.
package mic1_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
`ifdef MIC1_LOADER_CHECKSUM_EN
    S_DATA_LO,
    S_CKSUM
`else
    S_DATA_LO
`endif
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/mic1_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, LSB first.
// byte_valid / frame_err are single-cycle strobes at the stop-bit sample.
module mic1_uart_rx
  import mic1_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

  rx_state_t   state_q, state_d;
  logic [1:0]  sync_q;
  logic        prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx};
      prev_q  <= rx_s;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          // a start bit that is high again at mid-bit is a glitch
          state_d = rx_s ? RX_IDLE : RX_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) state_d = RX_IDLE;
        else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = (state_q == RX_STOP) && (cnt_q == FULL) && rx_s;
  assign frame_err  = (state_q == RX_STOP) && (cnt_q == FULL) && !rx_s;

endmodule

// File: rtl/mic1_uart_loader.sv
// UART boot loader: A5, CNT_HI, CNT_LO, N words (hi first) [, CKSUM].
// Trailing XOR checksum is enabled by MIC1_LOADER_CHECKSUM_EN.
module mic1_uart_loader
  import mic1_loader_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int          CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;

  mic1_uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        hi_q, hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              last, ok, fail;
  logic [15:0]       n;
`ifdef MIC1_LOADER_CHECKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MIC1_LOADER_CHECKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MIC1_LOADER_CHECKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    last    = 1'b0;
    ok      = 1'b0;
    fail    = 1'b0;
    n       = {hi_q, byte_data};
`ifdef MIC1_LOADER_CHECKSUM_EN
    cksum_d = cksum_q;
    if (byte_valid) begin
      if (state_q == S_IDLE) cksum_d = '0;
      else if (state_q != S_CKSUM) cksum_d = cksum_q ^ byte_data;
    end
`endif
    if (frame_err && state_q != S_IDLE) begin
      fail = 1'b1;
    end else if (byte_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (byte_data == SYNC_BYTE) begin
            state_d = S_CNT_HI;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            idx_d   = '0;
          end
        end
        S_CNT_HI: begin
          hi_d    = byte_data;
          state_d = S_CNT_LO;
        end
        S_CNT_LO: begin
          rem_d = n;
          if (n == 16'd0) last = 1'b1;
          else if ({1'b0, n} > MAX_N) fail = 1'b1;
          else state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = byte_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = {hi_q, byte_data};
          idx_d   = idx_q + 1'b1;
          rem_d   = rem_q - 16'd1;
          if (rem_q == 16'd1) last = 1'b1;
          else state_d = S_DATA_HI;
        end
`ifdef MIC1_LOADER_CHECKSUM_EN
        S_CKSUM: begin
          if (byte_data == cksum_q) ok = 1'b1;
          else fail = 1'b1;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
`ifdef MIC1_LOADER_CHECKSUM_EN
    if (last) state_d = S_CKSUM;
`else
    if (last) ok = 1'b1;
`endif
    if (ok) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
    if (fail) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end
    // hold outlives busy by one cycle so the CPU leaves reset last
    hold_d = busy_d | busy_q;
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_mic1_uart_loader.sv
// Directed bench for mic1_uart_loader at 4 clocks per UART bit.
// Expectations follow MIC1_LOADER_CHECKSUM_EN when it is defined.
module tb_mic1_uart_loader;

`ifdef MIC1_LOADER_CHECKSUM_EN
  localparam logic CK = 1'b1;
`else
  localparam logic CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int cyc = 0;
  int busy_fall = -1;
  int hold_fall = -1;
  logic busy_seen = 1'b0;
  logic busy_p = 1'b0;
  logic hold_p = 1'b0;
  logic [15:0] mem [0:4095];
  logic [7:0] seq [$];

  always #5 clk = ~clk;

  mic1_uart_loader #(
    .CLK_HZ(1000000),
    .BAUD  (250000),
    .ADDR_W(12),
    .DATA_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .load_done(load_done),
    .load_err (load_err)
  );

  always @(negedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      we_cnt++;
      mem[mem_addr] = mem_wdata;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
    if (busy_p && !busy) busy_fall = cyc;
    if (hold_p && !cpu_hold) hold_fall = cyc;
    busy_p = busy;
    hold_p = cpu_hold;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic send_seq(input int bad);
    for (int i = 0; i < seq.size(); i++)
      send_byte(seq[i], (i == bad) ? 1'b0 : 1'b1);
  endtask

  task automatic clear_mon();
    we_cnt    = 0;
    busy_seen = 1'b0;
    busy_fall = -1;
    hold_fall = -1;
    mem[0]    = 16'h0;
    mem[1]    = 16'h0;
  endtask

  task automatic good_frame(input string tag);
    clear_mon();
    seq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    send_seq(-1);
    idle(10);
    check({tag, "_we"}, we_cnt, 2);
    check({tag, "_mem0"}, mem[0], 16'h1234);
    check({tag, "_mem1"}, mem[1], 16'hABCD);
    check({tag, "_done"}, load_done, 1);
    check({tag, "_err"}, load_err, 0);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_tail"}, hold_fall - busy_fall, 1);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);
    check("rst_we", mem_we, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);

    clear_mon();
    seq = '{8'h00, 8'hFF, 8'h5A};
    send_seq(-1);
    idle(10);
    check("noise_we", we_cnt, 0);
    check("noise_busy", busy_seen, 0);

    good_frame("good");

    clear_mon();
    seq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    send_seq(-1);
    idle(10);
    check("badck_we", we_cnt, 2);
    check("badck_mem1", mem[1], 16'hABCD);
    check("badck_err", load_err, CK);
    check("badck_done", load_done, !CK);
    check("badck_tail", hold_fall - busy_fall, 1);

    clear_mon();
    seq = '{8'hA5, 8'h10, 8'h01};
    send_seq(-1);
    idle(10);
    check("big_err", load_err, 1);
    check("big_done", load_done, 0);
    check("big_we", we_cnt, 0);
    check("big_busy", busy, 0);

    good_frame("pre_stop");
    clear_mon();
    seq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
    send_seq(4);
    idle(10);
    check("stop_err", load_err, 1);
    check("stop_done", load_done, 0);
    check("stop_we", we_cnt, 0);
    check("stop_busy", busy, 0);

    clear_mon();
    seq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_seq(-1);
    check("mid_busy", busy, 1);
    @(negedge clk);
    rx = 1'b0;
    idle(6);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_hold", cpu_hold, 0);
    check("mrst_we", mem_we, 0);
    check("mrst_err", load_err, 0);
    rst = 1'b0;
    rx = 1'b1;
    idle(40);
    check("mrst_wcnt", we_cnt, 1);
    check("mrst_mem0", mem[0], 16'h1234);
    check("mrst_mem1", mem[1], 16'h0000);

    good_frame("after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
